// File: rtl/demux_stream_1x4_if.sv
`default_nettype none
// ============================================================================
// Module   : demux_stream_1x4_if
// Brief    : Upstream beat and four downstream valid/ready channels of the
//            1-to-4 stream demultiplexer.
// Revision : 1.0
// ============================================================================
interface demux_stream_1x4_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 2
);
  logic                  en;
  logic                  in_valid;
  logic [1:0]            in_sel;
  logic [DATA_W-1:0]     in_data;
  logic                  in_ready;
  logic [3:0]            out_valid;
  logic [4*DATA_W-1:0]   out_data;
  logic [3:0]            out_ready;
  logic [4*CNT_W-1:0]    occ;
  logic                  drop_err;

  modport master (
    output en, in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out_data, occ, drop_err
  );

  modport slave (
    input  en, in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data, occ, drop_err
  );
endinterface
`default_nettype wire

// File: rtl/demux_stream_1x4.sv
`default_nettype none
// ============================================================================
// Module   : demux_stream_1x4
// Brief    : Registered 1-to-4 demultiplexer with one small FIFO per channel,
//            each drained by its own valid/ready handshake.
// Revision : 1.0
// ============================================================================
module demux_stream_1x4 #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 2
) (
  input  wire logic             clk,
  input  wire logic             rst,
  demux_stream_1x4_if.slave     bus
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0]   mem    [4][DEPTH];
  logic [PTR_W-1:0]    wr_ptr [4];
  logic [PTR_W-1:0]    rd_ptr [4];
  logic [CNT_W-1:0]    count  [4];
  logic                drop_err_q;

  logic [3:0]          full;
  logic [3:0]          head_valid;
  logic [3:0]          pop;
  logic [3:0]          push;
  logic [4*DATA_W-1:0] head_data;
  logic [4*CNT_W-1:0]  occ_flat;
  logic                ready;
  logic                accept;

  always_comb begin
    full       = '0;
    head_valid = '0;
    pop        = '0;
    head_data  = '0;
    occ_flat   = '0;
    for (int k = 0; k < 4; k++) begin
      full[k]       = (count[k] == CNT_W'(DEPTH));
      head_valid[k] = (count[k] != '0);
      pop[k]        = head_valid[k] & bus.out_ready[k];
      // Empty channels present zero rather than stale storage.
      head_data[k*DATA_W +: DATA_W] = head_valid[k] ? mem[k][rd_ptr[k]] : '0;
      occ_flat[k*CNT_W +: CNT_W]    = count[k];
    end
  end

  assign ready  = bus.en & ~full[bus.in_sel];
  assign accept = bus.in_valid & ready;

  always_comb begin
    push = '0;
    for (int k = 0; k < 4; k++) begin
      push[k] = accept & (bus.in_sel == 2'(k));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
        count[k]  <= '0;
      end
      drop_err_q <= 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (push[k]) wr_ptr[k] <= wr_ptr[k] + PTR_W'(1);
        if (pop[k])  rd_ptr[k] <= rd_ptr[k] + PTR_W'(1);
        if (push[k] && !pop[k])      count[k] <= count[k] + CNT_W'(1);
        else if (pop[k] && !push[k]) count[k] <= count[k] - CNT_W'(1);
      end
      // Upstream offered a beat to a full channel: back-pressure ignored.
      if (bus.in_valid && bus.en && full[bus.in_sel]) drop_err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (push[k] && !rst) mem[k][wr_ptr[k]] <= bus.in_data;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = head_valid;
  assign bus.out_data  = head_data;
  assign bus.occ       = occ_flat;
  assign bus.drop_err  = drop_err_q;
endmodule
`default_nettype wire

// File: tb/tb_demux_stream_1x4.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_stream_1x4
// Brief    : Self-checking bench for demux_stream_1x4 against a queue model.
// Revision : 1.0
// ============================================================================
module tb_demux_stream_1x4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 2;
  localparam int CNT_W  = 2;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  logic [DATA_W-1:0] q [4][$];
  logic              drop_m;

  demux_stream_1x4_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus_if ();

  demux_stream_1x4 #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check in_ready, advance model, check outputs.
  task automatic step(input logic r, input logic e, input logic v, input logic [1:0] s,
                      input logic [7:0] d, input logic [3:0] rdy);
    logic exp_ready;
    logic [3:0] ev;
    rst              = r;
    bus_if.en        = e;
    bus_if.in_valid  = v;
    bus_if.in_sel    = s;
    bus_if.in_data   = d;
    bus_if.out_ready = rdy;
    #1;
    exp_ready = e && (q[s].size() < DEPTH);
    if (!r) chk("in_ready", 32'(bus_if.in_ready), 32'(exp_ready));
    @(posedge clk);
    if (r) begin
      for (int k = 0; k < 4; k++) q[k].delete();
      drop_m = 1'b0;
    end else begin
      if (v && e && q[s].size() == DEPTH) drop_m = 1'b1;
      for (int k = 0; k < 4; k++)
        if (q[k].size() > 0 && rdy[k]) void'(q[k].pop_front());
      if (v && exp_ready) q[s].push_back(d);
    end
    #1;
    ev = '0;
    for (int k = 0; k < 4; k++) begin
      ev[k] = (q[k].size() != 0);
      chk($sformatf("out_data%0d", k), 32'(bus_if.out_data[k*DATA_W +: DATA_W]),
          (q[k].size() != 0) ? 32'(q[k][0]) : 32'd0);
      chk($sformatf("occ%0d", k), 32'(bus_if.occ[k*CNT_W +: CNT_W]), 32'(q[k].size()));
    end
    chk("out_valid", 32'(bus_if.out_valid), 32'(ev));
    chk("drop_err", 32'(bus_if.drop_err), 32'(drop_m));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    drop_m  = 1'b0;
    rst = 1'b1;
    bus_if.en = 1'b0; bus_if.in_valid = 1'b0; bus_if.in_sel = 2'd0;
    bus_if.in_data = '0; bus_if.out_ready = 4'h0;

    // Reset, then single route to channel 2
    step(1, 0, 0, 0, 8'h00, 4'h0);
    step(1, 0, 0, 0, 8'h00, 4'h0);
    step(0, 1, 1, 2, 8'hA5, 4'h0);

    // Fill channel 1, overflow attempt, other channel still ready
    step(0, 1, 1, 1, 8'h11, 4'h0);
    step(0, 1, 1, 1, 8'h22, 4'h0);
    step(0, 1, 1, 1, 8'h33, 4'h0);
    step(0, 1, 1, 3, 8'h3C, 4'h0);
    step(0, 1, 0, 1, 8'h00, 4'h0);

    // FIFO order across pointer wrap
    step(1, 0, 0, 0, 8'h00, 4'h0);
    for (int i = 1; i <= 6; i++) step(0, 1, 1, 0, 8'(i), 4'b0001);
    step(0, 1, 0, 0, 8'h00, 4'b0001);

    // Simultaneous push and pop on channel 3
    step(1, 0, 0, 0, 8'h00, 4'h0);
    step(0, 1, 1, 3, 8'h40, 4'h0);
    step(0, 1, 1, 3, 8'h41, 4'b1000);
    step(0, 1, 0, 3, 8'h00, 4'h0);

    // Enable gating, then drain with en low
    step(0, 1, 1, 0, 8'h50, 4'h0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 8'hFF, 4'h0);
    step(0, 0, 1, 0, 8'hFF, 4'hF);
    step(0, 0, 0, 0, 8'h00, 4'hF);

    // Reset while channels 0 and 2 hold data and a push is offered
    step(0, 1, 1, 0, 8'h61, 4'h0);
    step(0, 1, 1, 0, 8'h62, 4'h0);
    step(0, 1, 1, 2, 8'h63, 4'h0);
    step(0, 1, 1, 2, 8'h64, 4'h0);
    step(1, 1, 1, 1, 8'h77, 4'hF);
    step(0, 1, 0, 1, 8'h00, 4'h0);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 59) == 0),
           ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 3) != 0),
           2'($urandom_range(0, 3)),
           8'($urandom),
           4'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/demux_stream_1x4.md
Name: demux_stream_1x4

Overview:
- Registered, flow-controlled 1-to-4 demultiplexer stage.
- Accepts a data beat with a 2-bit destination select and routes it into one of four per-channel FIFOs.
- Each FIFO drains independently through its own valid/ready handshake.
- Sits directly downstream of the combinational demux path and replaces the bare wire fan-out with buffered, back-pressured channels.

Parameters:
DATA_W, 8, width of each data beat
DEPTH, 2, entries per channel FIFO; power of two, >= 2
CNT_W, 2, width of per-channel occupancy count; must equal log2(DEPTH)+1

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
en  input  1  global enable; when 0, no beat is accepted
in_valid  input  1  upstream beat valid
in_sel  input  2  destination channel 0..3
in_data  input  DATA_W  upstream beat data
in_ready  output  1  stage can accept the beat now
out_valid  output  4  per-channel head-of-FIFO valid
out_data  output  4*DATA_W  packed head data; channel k at [k*DATA_W +: DATA_W]
out_ready  input  4  per-channel downstream ready
occ  output  4*CNT_W  packed per-channel occupancy; channel k at [k*CNT_W +: CNT_W]
drop_err  output  1  sticky error flag

Behaviour:
- Clock and reset:
  - Single clock domain; all state updates on rising clk.
  - rst is synchronous and active-high and takes priority over all other inputs.
- Reset values:
  - All FIFO pointers and counts = 0, so occ = 0 and out_valid = 4'b0000.
  - out_data = 0 and drop_err = 0.
  - FIFO storage contents are don't-care.
- in_ready:
  - Combinational: in_ready = en & ~full[in_sel], where full[k] = (count[k] == DEPTH).
  - Depends only on the selected channel's state, never on out_ready. There is no same-cycle pass-through.
- Push:
  - Occurs when in_valid & in_ready at the clock edge.
  - in_data is written to channel in_sel at its write pointer, and that pointer increments modulo DEPTH.
- Pop:
  - Occurs on channel k when out_valid[k] & out_ready[k]; the read pointer increments modulo DEPTH.
  - All four channels may pop in the same cycle.
- Head outputs:
  - out_valid[k] = (count[k] != 0).
  - out_data for channel k is the entry at read_ptr[k], combinational from storage. It holds stable while out_valid[k]=1 and out_ready[k]=0.
- Latency:
  - A beat accepted at edge N is visible on out_valid/out_data of its channel after edge N, i.e. 1 cycle, provided the FIFO was empty.
- Count update per channel:
  - count += push_k - pop_k.
  - Push and pop on the same channel in the same cycle leaves the count unchanged.
  - Push is impossible when full, because in_ready=0.
- Boundary cases:
  - Channel full: in_ready=0 for that in_sel only; other channels still accept.
  - A pop on a full channel frees space, visible on in_ready the next cycle.
  - Empty channel: out_ready is ignored; no pointer movement.
  - Pointer wrap: after DEPTH pushes the write pointer returns to 0. FIFO order is preserved across the wrap.
  - in_sel may change every cycle; routing uses in_sel sampled at the accepting edge.
  - en=0: in_ready=0, no pushes. Pops continue normally.
- drop_err:
  - Set at an edge where in_valid=1, en=1 and full[in_sel]=1. This indicates upstream is not honouring back-pressure.
  - Stays set until rst.
  - in_valid with en=0 does not set it.
- Reset mid-operation:
  - A rst asserted while FIFOs hold data discards all contents.
  - out_valid=0 from the cycle after the rst edge; no pop or push takes effect on that edge.

Test Plan:
1. Reset then single route: rst=1 for 2 cycles, then en=1, in_valid=1, in_sel=2, in_data=8'hA5 for 1 cycle, out_ready=0 -> next cycle out_valid=4'b0100, channel 2 data=A5, occ ch2=1; other channels occ=0.
2. Fill and back-pressure: push 8'h11, 8'h22 to ch1 with out_ready=0 -> occ ch1=2, in_ready=0 when in_sel=1. A third push of 8'h33 is not accepted and sets drop_err=1. in_sel=3 keeps in_ready=1.
3. FIFO order and wrap: continuously push 8'h01..8'h06 to ch0 with out_ready[0]=1 -> ch0 outputs 01..06 in order, each 1 cycle after acceptance. Pointers wrap with no loss or duplication.
4. Simultaneous push/pop: ch3 holds 1 entry (8'h40); same cycle push 8'h41 and pop with out_ready[3]=1 -> occ ch3 stays 1 and head becomes 41.
5. Enable gating: en=0, in_valid=1, in_sel=0, data 8'hFF for 3 cycles -> in_ready=0, occ unchanged, drop_err stays 0. Queued channels still drain when out_ready=1.
6. Reset mid-operation: ch0 and ch2 each hold 2 entries; assert rst for 1 cycle while pushing to ch1 -> after the edge out_valid=0, all occ=0, drop_err=0, and the ch1 beat is discarded.
